// File: rtl/a12_edge_filt.sv
// PPU A12 conditioner: synchronises A12/M2, deglitches A12, and qualifies rises by M2-measured low time.
// Emits one-clk rise/fall pulses aligned with the deglitched level.
module a12_edge_filt #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GLITCH_CLKS = 2,
    parameter int unsigned M2_LOW_MIN  = 3
) (
    input  logic       clk,
    input  logic       map_rst_n,
    input  logic       ppu_a12,
    input  logic       cpu_m2,
    input  logic       filt_en,
    input  logic       rej_clr,
    output logic       a12_lvl,
    output logic       a12_pe,
    output logic       a12_ne,
    output logic [3:0] low_cnt,
    output logic [7:0] rej_cnt
);

    typedef enum logic [1:0] {
        LOW_WAIT  = 2'd0,
        LOW_ARMED = 2'd1,
        HIGH      = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] a12_sync_q, a12_sync_d;
    logic [SYNC_STAGES-1:0] m2_sync_q, m2_sync_d;
    logic                   m2_prev_q, m2_prev_d;
    logic [2:0]             glitch_ctr_q, glitch_ctr_d;
    logic                   a12_lvl_q, a12_lvl_d;
    logic                   a12_pe_q, a12_pe_d;
    logic                   a12_ne_q, a12_ne_d;
    logic [3:0]             low_cnt_q, low_cnt_d;
    logic [7:0]             rej_cnt_q, rej_cnt_d;
    state_t                 state_q, state_d;

    logic a12_s, m2_s, m2_fall, toggle, rise, fall, rej_inc;

    always_comb begin
        a12_sync_d = {a12_sync_q[SYNC_STAGES-2:0], ppu_a12};
        m2_sync_d  = {m2_sync_q[SYNC_STAGES-2:0], cpu_m2};
        a12_s      = a12_sync_q[SYNC_STAGES-1];
        m2_s       = m2_sync_q[SYNC_STAGES-1];
        m2_prev_d  = m2_s;
        m2_fall    = m2_prev_q & ~m2_s;

        // Level changes only after GLITCH_CLKS consecutive disagreeing samples
        toggle       = 1'b0;
        glitch_ctr_d = '0;
        if (a12_s != a12_lvl_q) begin
            if (glitch_ctr_q == 3'(GLITCH_CLKS - 1)) begin
                toggle = 1'b1;
            end else begin
                glitch_ctr_d = glitch_ctr_q + 3'd1;
            end
        end
        rise      = toggle & ~a12_lvl_q;
        fall      = toggle & a12_lvl_q;
        a12_lvl_d = a12_lvl_q ^ toggle;

        if (a12_lvl_q) begin
            low_cnt_d = '0;
        end else if (m2_fall && (low_cnt_q != 4'hF)) begin
            low_cnt_d = low_cnt_q + 4'd1;
        end else begin
            low_cnt_d = low_cnt_q;
        end

        state_d  = state_q;
        a12_pe_d = 1'b0;
        a12_ne_d = 1'b0;
        rej_inc  = 1'b0;
        case (state_q)
            LOW_WAIT: begin
                // Pre-increment count decides, so a same-cycle M2 fall cannot qualify the rise
                if (rise) begin
                    state_d = HIGH;
                    if (!filt_en || (low_cnt_q >= 4'(M2_LOW_MIN))) begin
                        a12_pe_d = 1'b1;
                    end else begin
                        rej_inc = 1'b1;
                    end
                end else if (low_cnt_q >= 4'(M2_LOW_MIN)) begin
                    state_d = LOW_ARMED;
                end
            end
            LOW_ARMED: begin
                if (rise) begin
                    state_d  = HIGH;
                    a12_pe_d = 1'b1;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d  = LOW_WAIT;
                    a12_ne_d = 1'b1;
                end
            end
            default: state_d = LOW_WAIT;
        endcase

        if (rej_clr) begin
            rej_cnt_d = '0;
        end else if (rej_inc && (rej_cnt_q != 8'hFF)) begin
            rej_cnt_d = rej_cnt_q + 8'd1;
        end else begin
            rej_cnt_d = rej_cnt_q;
        end
    end

    always_ff @(posedge clk or negedge map_rst_n) begin
        if (!map_rst_n) begin
            a12_sync_q   <= '0;
            m2_sync_q    <= '0;
            m2_prev_q    <= 1'b0;
            glitch_ctr_q <= '0;
            a12_lvl_q    <= 1'b0;
            a12_pe_q     <= 1'b0;
            a12_ne_q     <= 1'b0;
            low_cnt_q    <= '0;
            rej_cnt_q    <= '0;
            state_q      <= LOW_WAIT;
        end else begin
            a12_sync_q   <= a12_sync_d;
            m2_sync_q    <= m2_sync_d;
            m2_prev_q    <= m2_prev_d;
            glitch_ctr_q <= glitch_ctr_d;
            a12_lvl_q    <= a12_lvl_d;
            a12_pe_q     <= a12_pe_d;
            a12_ne_q     <= a12_ne_d;
            low_cnt_q    <= low_cnt_d;
            rej_cnt_q    <= rej_cnt_d;
            state_q      <= state_d;
        end
    end

    assign a12_lvl = a12_lvl_q;
    assign a12_pe  = a12_pe_q;
    assign a12_ne  = a12_ne_q;
    assign low_cnt = low_cnt_q;
    assign rej_cnt = rej_cnt_q;

endmodule

// File: tb/tb_a12_edge_filt.sv
// Bench for a12_edge_filt: directed scenarios plus random pin activity, every cycle compared
// against a pin-history reference model.
module tb_a12_edge_filt;

    localparam int S    = 2;
    localparam int G    = 2;
    localparam int LMIN = 3;

    logic       clk = 1'b0;
    logic       map_rst_n, ppu_a12, cpu_m2, filt_en, rej_clr;
    logic       a12_lvl, a12_pe, a12_ne;
    logic [3:0] low_cnt;
    logic [7:0] rej_cnt;

    always #5 clk = ~clk;

    a12_edge_filt #(.SYNC_STAGES(S), .GLITCH_CLKS(G), .M2_LOW_MIN(LMIN)) dut (
        .clk(clk), .map_rst_n(map_rst_n), .ppu_a12(ppu_a12), .cpu_m2(cpu_m2),
        .filt_en(filt_en), .rej_clr(rej_clr), .a12_lvl(a12_lvl), .a12_pe(a12_pe),
        .a12_ne(a12_ne), .low_cnt(low_cnt), .rej_cnt(rej_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pin samples per edge (index 0 = newest), level, counts
    bit ah[0:7];
    bit mh[0:7];
    bit m_lvl, m_pe, m_ne;
    int m_low, m_rej, edge_no, last_tog;
    int pe_seen, ne_seen, lat, low_at_ne, hold;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            ah[i] = 1'b0;
            mh[i] = 1'b0;
        end
        m_lvl = 1'b0; m_pe = 1'b0; m_ne = 1'b0;
        m_low = 0; m_rej = 0;
        last_tog = edge_no;
    endfunction

    function automatic void model_step();
        bit tog, fall, rej_inc;
        int new_low;
        edge_no++;
        if (!map_rst_n) begin
            model_reset();
            return;
        end
        for (int i = 7; i > 0; i--) begin
            ah[i] = ah[i-1];
            mh[i] = mh[i-1];
        end
        ah[0] = ppu_a12;
        mh[0] = cpu_m2;
        // Level flips once the last G synchronised samples since the previous flip all disagree
        tog = (edge_no - last_tog) >= G;
        for (int i = 0; i < G; i++) if (ah[S+i] == m_lvl) tog = 1'b0;
        fall    = mh[S+1] && !mh[S];
        new_low = m_lvl ? 0 : ((fall && m_low < 15) ? m_low + 1 : m_low);
        m_pe = 1'b0; m_ne = 1'b0; rej_inc = 1'b0;
        if (tog && !m_lvl) begin
            if (!filt_en || m_low >= LMIN) m_pe = 1'b1;
            else rej_inc = 1'b1;
        end
        if (tog && m_lvl) m_ne = 1'b1;
        if (rej_clr) m_rej = 0;
        else if (rej_inc && m_rej < 255) m_rej++;
        if (tog) begin
            m_lvl = !m_lvl;
            last_tog = edge_no;
        end
        m_low = new_low;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("lvl", a12_lvl, m_lvl);
        check("pe", a12_pe, m_pe);
        check("ne", a12_ne, m_ne);
        check("low_cnt", low_cnt, m_low);
        check("rej_cnt", rej_cnt, m_rej);
        check("pe_ne_excl", a12_pe & a12_ne, 0);
        if (a12_pe) pe_seen++;
        if (a12_ne) begin
            ne_seen++;
            low_at_ne = low_cnt;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic m2_pulses(input int n, input int half);
        repeat (n) begin
            cpu_m2 = 1'b1;
            ticks(half);
            cpu_m2 = 1'b0;
            ticks(half);
        end
    endtask

    task automatic do_reset();
        map_rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_lvl", a12_lvl, 0);
        check("rst_pe", a12_pe, 0);
        check("rst_ne", a12_ne, 0);
        check("rst_low", low_cnt, 0);
        check("rst_rej", rej_cnt, 0);
        ticks(2);
        map_rst_n = 1'b1;
    endtask

    initial begin
        map_rst_n = 1'b0; ppu_a12 = 1'b0; cpu_m2 = 1'b0; filt_en = 1'b1; rej_clr = 1'b0;
        edge_no = 0; pe_seen = 0; ne_seen = 0; lat = 0; low_at_ne = -1; hold = 0;
        model_reset();

        // Qualified rise after 4 M2 periods low
        do_reset();
        ticks(4);
        m2_pulses(4, 3);
        ticks(6);
        check("t1_low_before_rise", low_cnt, 4);
        pe_seen = 0;
        ppu_a12 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (a12_pe && lat == 0) lat = i;
        end
        ticks(10);
        check("t1_latency", lat, 4);
        check("t1_pe_count", pe_seen, 1);

        // Too-short low time: rejected with filter, accepted without
        ppu_a12 = 1'b0;
        do_reset();
        ticks(6);
        m2_pulses(2, 3);
        ticks(4);
        pe_seen = 0;
        ppu_a12 = 1'b1;
        ticks(10);
        check("t2_rej_pe", pe_seen, 0);
        check("t2_rej_cnt", rej_cnt, 1);
        check("t2_rej_lvl", a12_lvl, 1);
        ppu_a12 = 1'b0;
        ticks(8);
        filt_en = 1'b0;
        m2_pulses(2, 3);
        pe_seen = 0;
        ppu_a12 = 1'b1;
        ticks(10);
        check("t2_nofilt_pe", pe_seen, 1);
        check("t2_nofilt_rej", rej_cnt, 1);
        filt_en = 1'b1;

        // 1-clk glitches every 5 clks
        ppu_a12 = 1'b0;
        ticks(8);
        pe_seen = 0; ne_seen = 0;
        repeat (10) begin
            ppu_a12 = 1'b1;
            tick();
            ppu_a12 = 1'b0;
            ticks(4);
        end
        ticks(4);
        check("t3_lvl", a12_lvl, 0);
        check("t3_pe", pe_seen, 0);
        check("t3_ne", ne_seen, 0);

        // Reject saturation, then clear colliding with a reject
        repeat (300) begin
            ppu_a12 = 1'b1;
            ticks(6);
            ppu_a12 = 1'b0;
            ticks(6);
        end
        check("t4_rej_sat", rej_cnt, 255);
        ppu_a12 = 1'b1;
        ticks(3);
        check("t4_rej_pre_clr", rej_cnt, 255);
        rej_clr = 1'b1;
        tick();
        rej_clr = 1'b0;
        check("t4_clr_lvl", a12_lvl, 1);
        check("t4_clr_pe", a12_pe, 0);
        check("t4_clr_rej", rej_cnt, 0);

        // low_cnt saturation and falling-edge pulse
        ppu_a12 = 1'b0;
        ticks(8);
        m2_pulses(20, 2);
        ticks(4);
        check("t5_low_sat", low_cnt, 15);
        ppu_a12 = 1'b1;
        ticks(8);
        ne_seen = 0; low_at_ne = -1;
        ppu_a12 = 1'b0;
        ticks(8);
        check("t5_ne_count", ne_seen, 1);
        check("t5_low_at_ne", low_at_ne, 0);

        // Reset while armed forces full low time again
        m2_pulses(4, 3);
        ticks(4);
        check("t6_armed_low", low_cnt, 4);
        do_reset();
        m2_pulses(1, 3);
        ticks(3);
        pe_seen = 0;
        ppu_a12 = 1'b1;
        ticks(10);
        check("t6_pe", pe_seen, 0);
        check("t6_rej", rej_cnt, 1);

        // Random pin activity
        for (int n = 0; n < 3000; n++) begin
            if (hold == 0) begin
                ppu_a12 = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 12);
            end
            hold--;
            if ($urandom_range(0, 2) == 0) cpu_m2 = ~cpu_m2;
            if ($urandom_range(0, 99) == 0) filt_en = ~filt_en;
            rej_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
